multi_timer_dev: RTL and testbench

// - N-channel programmable down-counter peripheral on the CPU memory-mapped I/O bus.
// - Each channel has CTRL/PRESET/COUNT/STATUS, one-shot or auto-reload mode, and a sticky maskable interrupt.
// - Per-channel IRQs feed the CP0 interrupt inputs; irq_any is the OR-reduced request.
// - Bus writes are synchronous to clk; there is no separate write-strobe clock.

---
 rtl/multi_timer_dev_pkg.sv | 17 +
 rtl/multi_timer_dev_if.sv | 14 +
 rtl/multi_timer_dev_channel.sv | 75 +++++++
 rtl/multi_timer_dev.sv | 38 +++
 tb/tb_multi_timer_dev.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/multi_timer_dev_pkg.sv
// timer_pkg: register offsets, mode encodings and CTRL bit positions shared by the timer block
package timer_pkg;
  typedef enum logic [1:0] {
    REG_CTRL   = 2'b00,
    REG_PRESET = 2'b01,
    REG_COUNT  = 2'b10,
    REG_STATUS = 2'b11
  } reg_e;
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_PSC_LO  = 8;
  localparam int CTRL_PSC_HI  = 15;
endpackage

// File: rtl/multi_timer_dev_if.sv
// multi_timer_dev_if: memory-mapped timer bus; master drives addr/we/wdata, slave returns rdata/irq/irq_any
interface multi_timer_dev_if #(
  parameter int NUM_CH = 4,
  parameter int AW     = $clog2(NUM_CH) + 2
);
  logic [AW-1:0]     addr;
  logic              we;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [NUM_CH-1:0] irq;
  logic              irq_any;
  modport master (output addr, we, wdata, input rdata, irq, irq_any);
  modport slave  (input addr, we, wdata, output rdata, irq, irq_any);
endinterface

// File: rtl/multi_timer_dev_channel.sv
// timer_channel: one down-counter channel (CTRL/PRESET/COUNT/STATUS, prescaler under TIMER_PRESCALE_EN)
// Ports: clk, reset (async, active-high); we_i/reg_i/wdata_i register write; rdata_o read data; irq_o request
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  reg_e        reg_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);
  logic             en_q, en_d, im_q, im_d, pend_q, pend_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] preset_q, preset_d, count_q, count_d;
  logic [7:0]       psc;
  logic             tick, term, reload, ctrl_we, preset_we, status_we;
  assign ctrl_we   = we_i && reg_i == REG_CTRL;
  assign preset_we = we_i && reg_i == REG_PRESET;
  assign status_we = we_i && reg_i == REG_STATUS;
`ifdef TIMER_PRESCALE_EN
  logic [7:0] psc_q, pcnt_q, pcnt_d;
  assign psc    = psc_q;
  assign tick   = en_q && pcnt_q == psc_q;
  // idle or disabled prescaler sits at zero, so EN 0->1 (always a CTRL write) starts a fresh period
  assign pcnt_d = (ctrl_we || !en_q || tick) ? 8'd0 : pcnt_q + 8'd1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      psc_q  <= '0;
      pcnt_q <= '0;
    end else begin
      psc_q  <= ctrl_we ? wdata_i[CTRL_PSC_HI:CTRL_PSC_LO] : psc_q;
      pcnt_q <= pcnt_d;
    end
`else
  assign psc  = '0;
  assign tick = en_q;
`endif
  assign reload = mode_q == MODE_RELOAD;
  assign term   = tick && count_q == '0;
  // bus writes override tick updates of the same register; a terminal event overrides a W1C
  always_comb begin
    en_d     = ctrl_we ? wdata_i[CTRL_EN] : (term && !reload) ? 1'b0 : en_q;
    mode_d   = ctrl_we ? wdata_i[CTRL_MODE_HI:CTRL_MODE_LO] : mode_q;
    im_d     = ctrl_we ? wdata_i[CTRL_IM] : im_q;
    preset_d = preset_we ? wdata_i[CNT_W-1:0] : preset_q;
    count_d  = preset_we ? wdata_i[CNT_W-1:0] :
               term      ? (reload ? preset_q : count_q) :
               tick      ? count_q - CNT_W'(1) : count_q;
    pend_d   = term || (pend_q && !(status_we && wdata_i[0]));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      en_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      im_q     <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  assign rdata_o = reg_i == REG_CTRL   ? {16'h0, psc, 4'h0, im_q, mode_q, en_q} :
                   reg_i == REG_PRESET ? 32'(preset_q) :
                   reg_i == REG_COUNT  ? 32'(count_q) : {31'h0, pend_q};
  assign irq_o = pend_q & im_q;
endmodule

// File: rtl/multi_timer_dev.sv
// multi_timer_dev: NUM_CH programmable down-counter timers on a memory-mapped bus (prescaler: TIMER_PRESCALE_EN)
// Ports: clk, reset (async, active-high); bus (slave): addr {channel, reg}, we, wdata, rdata, irq, irq_any
module multi_timer_dev
  import timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int AW     = $clog2(NUM_CH) + 2
) (
  input logic              clk,
  input logic              reset,
  multi_timer_dev_if.slave bus
);
  logic [AW-1:0]     a;
  logic [31:0]       idx;
  logic [31:0]       rd [NUM_CH];
  logic [NUM_CH-1:0] irq;
  assign a   = bus.addr;
  assign idx = 32'(a >> 2);
  // channel indices >= NUM_CH match no channel, so they read 0 and write nothing
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .we_i    (bus.we && idx == 32'(i)),
      .reg_i   (reg_e'(a[1:0])),
      .wdata_i (bus.wdata),
      .rdata_o (rd[i]),
      .irq_o   (irq[i])
    );
  end
  always_comb begin
    bus.rdata = '0;
    for (int k = 0; k < NUM_CH; k++) bus.rdata = idx == 32'(k) ? rd[k] : bus.rdata;
  end
  assign bus.irq     = irq;
  assign bus.irq_any = |irq;
endmodule

// File: tb/tb_multi_timer_dev.sv
// tb_multi_timer_dev: directed bench with behavioural register model and per-cycle comparison
module tb_multi_timer_dev;
  import timer_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  multi_timer_dev_if #(.NUM_CH(4)) bus ();
  multi_timer_dev_if #(.NUM_CH(3)) b2 ();
  multi_timer_dev #(.NUM_CH(4), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  multi_timer_dev #(.NUM_CH(3), .CNT_W(16)) dut2 (.clk(clk), .reset(reset), .bus(b2));
`ifdef TIMER_PRESCALE_EN
  localparam int PSC_LAT = 10;
  localparam logic [31:0] PSC_CTRL = 32'h409;
`else
  localparam int PSC_LAT = 2;
  localparam logic [31:0] PSC_CTRL = 32'h9;
`endif
  int n_chk = 0;
  int n_fail = 0;
  bit ready = 0;
  logic [31:0] m_cnt [4];
  logic [31:0] m_pre [4];
  bit          m_en [4];
  bit   [1:0]  m_mode [4];
  bit          m_im [4];
  bit          m_pend [4];
  int          m_psc [4];
  int          m_pc [4];
  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  function automatic logic [3:0] ad(int c, int r);
    return 4'((c << 2) | r);
  endfunction
  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_cnt[c] = 0; m_pre[c] = 0; m_en[c] = 0; m_mode[c] = 0;
      m_im[c] = 0; m_pend[c] = 0; m_psc[c] = 0; m_pc[c] = 0;
    end
  endtask
  // ticks happen on enabled cycles whose count since the last CTRL write hits PSC mod PSC+1;
  // the bus write is laid over the tick result afterwards, so writes win
  task automatic model_step(logic w, logic [3:0] a, logic [31:0] d);
    for (int c = 0; c < 4; c++) begin
      bit tk, tm;
      tk = m_en[c] && (m_pc[c] % (m_psc[c] + 1) == m_psc[c]);
      tm = 0;
      if (m_en[c]) m_pc[c]++;
      if (tk && m_cnt[c] == 0) begin
        tm = 1;
        m_pend[c] = 1;
        if (m_mode[c] == 2'b01) m_cnt[c] = m_pre[c];
        else m_en[c] = 0;
      end else if (tk) m_cnt[c] = m_cnt[c] - 1;
      if (w && int'(a[3:2]) == c) begin
        if (a[1:0] == 2'd0) begin
          m_en[c] = d[0]; m_mode[c] = d[2:1]; m_im[c] = d[3]; m_pc[c] = 0;
`ifdef TIMER_PRESCALE_EN
          m_psc[c] = int'(d[15:8]);
`endif
        end else if (a[1:0] == 2'd1) begin
          m_pre[c] = d; m_cnt[c] = d;
        end else if (a[1:0] == 2'd3 && d[0] && !tm) m_pend[c] = 0;
      end
    end
  endtask
  function automatic logic [31:0] model_rd(logic [3:0] a);
    int c = int'(a[3:2]);
    case (a[1:0])
      2'd0: return {16'h0, 8'(m_psc[c]), 4'h0, m_im[c], m_mode[c], m_en[c]};
      2'd1: return m_pre[c];
      2'd2: return m_cnt[c];
      default: return {31'h0, m_pend[c]};
    endcase
  endfunction
  function automatic logic [31:0] model_irq();
    logic [31:0] r = 0;
    for (int c = 0; c < 4; c++) r[c] = m_pend[c] & m_im[c];
    return r;
  endfunction
  always @(negedge clk)
    if (ready) begin
      check("cmp_rdata", bus.rdata, model_rd(bus.addr));
      check("cmp_irq", 32'(bus.irq), model_irq());
      check("cmp_irq_any", 32'(bus.irq_any), 32'(model_irq() != 0));
    end
  task automatic adv();
    @(posedge clk);
    if (reset) model_reset();
    else model_step(bus.we, bus.addr, bus.wdata);
    #2;
  endtask
  task automatic step(logic w, logic [3:0] a, logic [31:0] d);
    adv();
    bus.we = w; bus.addr = a; bus.wdata = d;
  endtask
  task automatic peek(logic [3:0] a, logic [31:0] exp, string nm);
    step(0, a, 0);
    #1 check(nm, bus.rdata, exp);
  endtask
  task automatic step2(logic w, logic [3:0] a, logic [31:0] d);
    adv();
    bus.we = 0;
    b2.we = w; b2.addr = a; b2.wdata = d;
  endtask
  task automatic peek2(logic [3:0] a, logic [31:0] exp, string nm);
    step2(0, a, 0);
    #1 check(nm, b2.rdata, exp);
  endtask
  initial begin
    int got;
    bus.we = 0; bus.addr = 0; bus.wdata = 0;
    b2.we = 0; b2.addr = 0; b2.wdata = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 reset = 0;
    ready = 1;
    peek(ad(0, 0), 0, "rst_ctrl");
    peek(ad(2, 2), 0, "rst_count");
    // one-shot ch0
    step(1, ad(0, 1), 3);
    step(1, ad(0, 0), 9);
    peek(ad(0, 2), 3, "os_cnt3");
    peek(ad(0, 2), 2, "os_cnt2");
    peek(ad(0, 2), 1, "os_cnt1");
    peek(ad(0, 2), 0, "os_cnt0");
    peek(ad(0, 3), 1, "os_status");
    check("os_irq0", 32'(bus.irq[0]), 1);
    peek(ad(0, 0), 8, "os_en_clr");
    peek(ad(0, 2), 0, "os_cnt_hold");
    // auto-reload ch1, period 3
    step(1, ad(1, 1), 2);
    step(1, ad(1, 0), 11);
    peek(ad(1, 2), 2, "rl_cnt2");
    peek(ad(1, 2), 1, "rl_cnt1");
    peek(ad(1, 2), 0, "rl_cnt0");
    peek(ad(1, 3), 1, "rl_status");
    step(1, ad(1, 3), 1);
    peek(ad(1, 3), 0, "rl_w1c");
    peek(ad(1, 3), 1, "rl_period");
    step(1, ad(1, 3), 1);
    step(1, ad(1, 3), 1);
    #1 check("rl_clr", bus.rdata, 0);
    peek(ad(1, 3), 1, "rl_w1c_collide");
    check("rl_irq1", 32'(bus.irq[1]), 1);
    // masked ch2
    step(1, ad(2, 1), 2);
    step(1, ad(2, 0), 1);
    repeat (3) step(0, ad(2, 3), 0);
    peek(ad(2, 3), 1, "mask_status");
    check("mask_irq_off", 32'(bus.irq[2]), 0);
    step(1, ad(2, 0), 8);
    peek(ad(2, 0), 8, "mask_ctrl");
    check("mask_irq_on", 32'(bus.irq[2]), 1);
    // PRESET write on a tick cycle, ch3
    step(1, ad(3, 1), 10);
    step(1, ad(3, 0), 3);
    step(0, ad(3, 2), 0);
    step(1, ad(3, 1), 20);
    peek(ad(3, 2), 20, "coll_load");
    peek(ad(3, 2), 19, "coll_next");
    // prescaler latency on ch0
    step(1, ad(0, 3), 1);
    step(1, ad(0, 1), 1);
    step(1, ad(0, 0), 32'h409);
    peek(ad(0, 0), PSC_CTRL, "psc_ctrl");
    got = 99;
    for (int n = 1; n <= 20; n++) begin
      step(0, ad(0, 3), 0);
      #1 if (bus.rdata == 1) begin got = n; break; end
    end
    check("psc_latency", 32'(got), 32'(PSC_LAT));
    // second instance: 3 channels, 16-bit counters
    step2(1, 4'h1, 32'h12345);
    peek2(4'h1, 32'h2345, "w16_preset");
    peek2(4'h2, 32'h2345, "w16_count");
    step2(1, 4'hC, 9);
    step2(1, 4'hD, 32'h55);
    peek2(4'hC, 0, "oor_ctrl");
    peek2(4'hD, 0, "oor_preset");
    peek2(4'hE, 0, "oor_count");
    peek2(4'h1, 32'h2345, "oor_no_alias");
    peek2(4'h0, 0, "oor_ch0_ctrl");
    check("oor_irq_any", 32'(b2.irq_any), 0);
    // asynchronous reset mid-count
    step(1, ad(0, 1), 100);
    step(1, ad(0, 0), 9);
    step(0, ad(1, 3), 0);
    #1 check("pre_rst_irq_any", 32'(bus.irq_any), 1);
    reset = 1;
    model_reset();
    #1 check("rst_status", bus.rdata, 0);
    check("rst_irq", 32'(bus.irq), 0);
    check("rst_irq_any", 32'(bus.irq_any), 0);
    bus.addr = ad(0, 2);
    #1 check("rst_cnt0", bus.rdata, 0);
    step(0, ad(0, 0), 0);
    reset = 0;
    peek(ad(0, 2), 0, "post_rst_cnt");
    @(negedge clk);
    #1 $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
